// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings for the control unit and its instruction decoder
//
// Holds the opcode/funct3/funct7 values that are accepted, the FSM state
// enumeration and the instruction class produced by the decoder.

package rv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_DOUBLE  = 3'b011;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_ALU_R   = 3'd1,
      CLS_ALU_I   = 3'd2,
      CLS_LOAD    = 3'd3,
      CLS_STORE   = 3'd4
   } instr_class_t;

   // Loads and stores need the extra MEM cycle after EXEC.
   function automatic logic is_mem_class(input instr_class_t c);
      return (c == CLS_LOAD) || (c == CLS_STORE);
   endfunction

   function automatic logic is_alu_class(input instr_class_t c);
      return (c == CLS_ALU_R) || (c == CLS_ALU_I);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational decode of the instruction register
//
// Ports:
//   ir           in   32  latched instruction word
//   rs1/rs2/rd   out  5   raw register select fields
//   immediate    out  12  I-type or S-type immediate, 0 for R-type/illegal
//   sub          out  1   ALU subtract, R-type only
//   ula_din2_sel out  1   1 = immediate as ALU operand 2
//   iclass       out      instruction class
//   legal        out  1   encoding is one of the supported instructions

module instr_decoder
   import rv_pkg::*;
(
   input  logic [31:0]  ir,
   output logic [4:0]   rs1,
   output logic [4:0]   rs2,
   output logic [4:0]   rd,
   output logic [11:0]  immediate,
   output logic         sub,
   output logic         ula_din2_sel,
   output instr_class_t iclass,
   output logic         legal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign rd  = ir[11:7];

   always_comb begin
      iclass = CLS_ILLEGAL;
      case (opcode)
         OPC_OP: begin
            if ((funct3 == F3_ADD_SUB) && ((funct7 == F7_ADD) || (funct7 == F7_SUB)))
               iclass = CLS_ALU_R;
         end
         OPC_OP_IMM: begin
            if (funct3 == F3_ADD_SUB)
               iclass = CLS_ALU_I;
         end
         OPC_LOAD: begin
            if (funct3 == F3_DOUBLE)
               iclass = CLS_LOAD;
         end
         OPC_STORE: begin
            if (funct3 == F3_DOUBLE)
               iclass = CLS_STORE;
         end
         default: iclass = CLS_ILLEGAL;
      endcase
   end

   assign legal = (iclass != CLS_ILLEGAL);

   always_comb begin
      immediate = 12'h000;
      case (iclass)
         CLS_ALU_I, CLS_LOAD: immediate = ir[31:20];
         CLS_STORE:           immediate = {ir[31:25], ir[11:7]};
         default:             immediate = 12'h000;
      endcase
   end

   assign sub          = (iclass == CLS_ALU_R) && ir[30];
   assign ula_din2_sel = (iclass == CLS_ALU_I) || (iclass == CLS_LOAD) || (iclass == CLS_STORE);

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute controller
//
// Parameters:
//   IM_ADDR_W  width of PC / IM_ADDR
//   RESET_PC   PC value after reset
// Ports:
//   CLK, RST             clock, async active-high reset
//   IM_REQ/IM_ADDR       fetch request and address (PC)
//   IM_ACK/IM_DATA       fetch completion and instruction word
//   rs1/rs2/rd/immediate decoded operand selects to the datapath
//   sub, ULA_din2_sel    ALU controls
//   WE_RF, WE_MEM        single-cycle write strobes
//   RF_din_sel           1 = ALU result, 0 = memory data into regfile
//   INSTR_DONE           one-cycle retire pulse
//   ILLEGAL              sticky unsupported-instruction flag

module control_unit
   import rv_pkg::*;
#(
   parameter int                   IM_ADDR_W = 32,
   parameter logic [IM_ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic                 IM_REQ,
   output logic [IM_ADDR_W-1:0] IM_ADDR,
   input  logic                 IM_ACK,
   input  logic [31:0]          IM_DATA,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic [11:0]          immediate,
   output logic                 sub,
   output logic                 WE_RF,
   output logic                 WE_MEM,
   output logic                 RF_din_sel,
   output logic                 ULA_din2_sel,
   output logic                 INSTR_DONE,
   output logic                 ILLEGAL
);

   state_t                 state;
   state_t                 state_nxt;
   logic [IM_ADDR_W-1:0]   pc;
   logic [31:0]            ir;
   logic                   illegal_q;
   instr_class_t           iclass;
   logic                   legal;

   instr_decoder u_dec (
      .ir           (ir),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .immediate    (immediate),
      .sub          (sub),
      .ula_din2_sel (ULA_din2_sel),
      .iclass       (iclass),
      .legal        (legal)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (IM_ACK) state_nxt = S_DECODE;
         S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
         S_EXEC:   state_nxt = is_mem_class(iclass) ? S_MEM : S_FETCH;
         S_MEM:    state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_HALT;
      endcase
   end

   // Outputs are decoded from the state alone, so an asynchronous reset
   // drops every strobe immediately without waiting for a clock edge.
   always_comb begin
      IM_REQ     = 1'b0;
      WE_RF      = 1'b0;
      WE_MEM     = 1'b0;
      INSTR_DONE = 1'b0;
      case (state)
         S_FETCH: IM_REQ = 1'b1;
         S_EXEC: begin
            if (is_alu_class(iclass)) begin
               WE_RF      = (rd != 5'd0);
               INSTR_DONE = 1'b1;
            end
         end
         S_MEM: begin
            WE_RF      = (iclass == CLS_LOAD) && (rd != 5'd0);
            WE_MEM     = (iclass == CLS_STORE);
            INSTR_DONE = 1'b1;
         end
         default: ;
      endcase
   end

   // Mux select follows the instruction class so it is already settled
   // before the write strobe appears.
   assign RF_din_sel = (iclass != CLS_LOAD);
   assign IM_ADDR    = pc;
   assign ILLEGAL    = illegal_q;

   // PC, IR and the sticky illegal flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc        <= RESET_PC;
         ir        <= 32'h0000_0000;
         illegal_q <= 1'b0;
      end else begin
         if ((state == S_FETCH) && IM_ACK)
            ir <= IM_DATA;
         if ((state == S_DECODE) && !legal)
            illegal_q <= 1'b1;
         // Natural wrap of the IM_ADDR_W-bit adder gives the modulo increment.
         if (INSTR_DONE)
            pc <= pc + IM_ADDR_W'(32'd4);
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit

module tb_control_unit;

   localparam int K_R   = 0;
   localparam int K_I   = 1;
   localparam int K_L   = 2;
   localparam int K_S   = 3;
   localparam int K_ILL = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IM_ACK = 1'b0;
   logic [31:0] IM_DATA = 32'h0;
   logic        IM_REQ;
   logic [31:0] IM_ADDR;
   logic [4:0]  rs1, rs2, rd;
   logic [11:0] immediate;
   logic        sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, INSTR_DONE, ILLEGAL;

   logic        IM_ACK_w = 1'b0;
   logic [31:0] IM_DATA_w = 32'h0;
   logic        IM_REQ_w;
   logic [31:0] IM_ADDR_w;
   logic [4:0]  rs1_w, rs2_w, rd_w;
   logic [11:0] immediate_w;
   logic        sub_w, WE_RF_w, WE_MEM_w, RF_din_sel_w, ULA_din2_sel_w, INSTR_DONE_w, ILLEGAL_w;

   always #5 CLK = ~CLK;

   control_unit #(.IM_ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK),
      .IM_DATA(IM_DATA), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
      .sub(sub), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
      .ULA_din2_sel(ULA_din2_sel), .INSTR_DONE(INSTR_DONE), .ILLEGAL(ILLEGAL)
   );

   control_unit #(.IM_ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .CLK(CLK), .RST(RST), .IM_REQ(IM_REQ_w), .IM_ADDR(IM_ADDR_w), .IM_ACK(IM_ACK_w),
      .IM_DATA(IM_DATA_w), .rs1(rs1_w), .rs2(rs2_w), .rd(rd_w), .immediate(immediate_w),
      .sub(sub_w), .WE_RF(WE_RF_w), .WE_MEM(WE_MEM_w), .RF_din_sel(RF_din_sel_w),
      .ULA_din2_sel(ULA_din2_sel_w), .INSTR_DONE(INSTR_DONE_w), .ILLEGAL(ILLEGAL_w)
   );

   typedef struct {
      logic [31:0] word;
      int          kind;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [11:0] imm;
      logic        sub;
      int          delay;
   } vec_t;

   vec_t        tbl [6];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] pc_model = 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Fields the spec defines for each format; undefined ones are masked out.
   function automatic logic [28:0] pack_f(input int kind, input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] d, input logic [11:0] im,
                                          input logic s, input logic dn);
      logic [4:0] bm, dm;
      bm = (kind == K_R || kind == K_S) ? b : 5'd0;
      dm = (kind == K_S) ? 5'd0 : d;
      return {a, bm, dm, im, s, dn};
   endfunction

   // Starts and ends at posedge+1 with the DUT in FETCH.
   task automatic run_instr(input vec_t v, input string tag);
      int          lat;
      logic [3:0]  rf_tr, mem_tr, done_tr, req_tr, exp_rf, exp_mem, exp_done;
      logic [28:0] first_f, exp_f, cur_f;
      logic        stable, din_last, ill_last;
      lat = (v.kind == K_L || v.kind == K_S) ? 3 : ((v.kind == K_ILL) ? 1 : 2);
      for (int d = 0; d < v.delay; d++) begin
         IM_ACK = 1'b0; IM_DATA = $urandom;
         @(negedge CLK);
         chk({tag, " wait req/addr"}, {IM_REQ, IM_ADDR}, {1'b1, pc_model});
         @(posedge CLK); #1;
      end
      IM_ACK = 1'b1; IM_DATA = v.word;
      @(negedge CLK);
      chk({tag, " ack req/addr"}, {IM_REQ, IM_ADDR}, {1'b1, pc_model});
      @(posedge CLK); #1;
      rf_tr = '0; mem_tr = '0; done_tr = '0; req_tr = '0;
      stable = 1'b1; first_f = '0; din_last = 1'b0; ill_last = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         IM_ACK = 1'($urandom_range(0, 1)); IM_DATA = $urandom;
         @(negedge CLK);
         rf_tr[c-1]   = WE_RF;
         mem_tr[c-1]  = WE_MEM;
         done_tr[c-1] = INSTR_DONE;
         req_tr[c-1]  = IM_REQ;
         cur_f = pack_f(v.kind, rs1, rs2, rd, immediate, sub, ULA_din2_sel);
         if (c == 1) first_f = cur_f;
         else if (cur_f !== first_f) stable = 1'b0;
         if (c == lat) begin din_last = RF_din_sel; ill_last = ILLEGAL; end
         @(posedge CLK); #1;
      end
      IM_ACK = 1'b0;
      exp_rf = '0; exp_mem = '0; exp_done = '0;
      if (v.kind != K_ILL) exp_done[lat-1] = 1'b1;
      if ((v.kind == K_R || v.kind == K_I || v.kind == K_L) && v.rd != 5'd0) exp_rf[lat-1] = 1'b1;
      if (v.kind == K_S) exp_mem[lat-1] = 1'b1;
      chk({tag, " strobes rf/mem/done/req"}, {rf_tr, mem_tr, done_tr, req_tr},
          {exp_rf, exp_mem, exp_done, 4'b0000});
      if (v.kind != K_ILL) begin
         exp_f = pack_f(v.kind, v.rs1, v.rs2, v.rd, v.imm, v.sub, (v.kind != K_R));
         chk({tag, " fields"}, first_f, exp_f);
         chk({tag, " fields stable"}, stable, 1'b1);
         chk({tag, " illegal clear"}, ill_last, 1'b0);
         if (v.kind != K_S)
            chk({tag, " rf_din_sel"}, din_last, (v.kind != K_L));
         pc_model = pc_model + 32'd4;
      end
   endtask

   task automatic check_halt(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         IM_ACK = 1'($urandom_range(0, 1)); IM_DATA = $urandom;
         @(negedge CLK);
         chk(tag, {IM_REQ, WE_RF, WE_MEM, INSTR_DONE, ILLEGAL, IM_ADDR}, {5'b00001, pc_model});
         @(posedge CLK); #1;
      end
      IM_ACK = 1'b0;
   endtask

   task automatic reset_dut(input string tag);
      @(posedge CLK); #1;
      IM_ACK = 1'b0; RST = 1'b1;
      #1;
      chk({tag, " async"}, {IM_ADDR, WE_RF, WE_MEM, INSTR_DONE, ILLEGAL}, {32'h0, 4'b0000});
      @(posedge CLK); #1;
      RST = 1'b0; pc_model = 32'h0;
      @(negedge CLK);
      chk({tag, " refetch"}, {IM_REQ, IM_ADDR}, {1'b1, 32'h0});
      @(posedge CLK); #1;
   endtask

   initial begin
      vec_t        v;
      int          r;
      logic [11:0] im;

      tbl[0] = '{32'h002081B3, K_R, 5'd1, 5'd2, 5'd3, 12'h000, 1'b0, 0};
      tbl[1] = '{32'h402081B3, K_R, 5'd1, 5'd2, 5'd3, 12'h000, 1'b1, 1};
      tbl[2] = '{32'hFFF00293, K_I, 5'd0, 5'd0, 5'd5, 12'hFFF, 1'b0, 0};
      tbl[3] = '{32'h0080B303, K_L, 5'd1, 5'd0, 5'd6, 12'h008, 1'b0, 2};
      tbl[4] = '{32'h0020B823, K_S, 5'd1, 5'd2, 5'd0, 12'h010, 1'b0, 5};
      tbl[5] = '{32'h00100013, K_I, 5'd0, 5'd0, 5'd0, 12'h001, 1'b0, 0};

      // Reset applied between clock edges
      #2 RST = 1'b1;
      #1;
      chk("reset outputs", {IM_REQ, WE_RF, WE_MEM, INSTR_DONE, ILLEGAL, IM_ADDR}, {5'b10000, 32'h0});
      chk("reset ir fields", {rs1, rs2, rd, immediate, sub}, 28'h0);
      chk("reset pc wrap dut", IM_ADDR_w, 32'hFFFF_FFFC);
      @(posedge CLK); #1;
      RST = 1'b0;
      pc_model = 32'h0;

      // PC wrap: addi x0 at 0xFFFFFFFC
      @(negedge CLK);
      chk("wrap start addr", {IM_REQ_w, IM_ADDR_w}, {1'b1, 32'hFFFF_FFFC});
      @(posedge CLK); #1;
      IM_ACK_w = 1'b1; IM_DATA_w = 32'h00100013;
      @(posedge CLK); #1;
      IM_ACK_w = 1'b0;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("wrap retire rf/done", {WE_RF_w, INSTR_DONE_w}, 2'b01);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("wrap next addr", {IM_REQ_w, IM_ADDR_w}, {1'b1, 32'h0});
      @(posedge CLK); #1;

      // Directed vectors
      for (int i = 0; i < 6; i++)
         run_instr(tbl[i], $sformatf("vec%0d", i));
      @(negedge CLK);
      chk("pc after table", IM_ADDR, 32'd24);
      @(posedge CLK); #1;

      // Reset pulse while an sd is in MEM
      IM_ACK = 1'b1; IM_DATA = 32'h0020B823;
      @(posedge CLK); #1;
      IM_ACK = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      #1;
      chk("rst in mem", {WE_MEM, WE_RF, INSTR_DONE, IM_ADDR}, {3'b000, 32'h0});
      @(negedge CLK);
      chk("rst in mem held", WE_MEM, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0; pc_model = 32'h0;
      @(negedge CLK);
      chk("after rst in mem", {IM_REQ, WE_MEM, IM_ADDR}, {2'b10, 32'h0});
      @(posedge CLK); #1;

      // All-zero word is illegal: halt until reset
      run_instr(tbl[0], "pre-ill");
      v = '{32'h0000_0000, K_ILL, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1};
      run_instr(v, "ill zero");
      check_halt(8, "halt zero");
      reset_dut("ill reset");

      // Randomized instructions against the encoding model
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         v.kind  = (r < 9) ? (r % 4) : K_ILL;
         v.rs1   = 5'($urandom_range(0, 31));
         v.rs2   = 5'($urandom_range(0, 31));
         v.rd    = 5'($urandom_range(0, 31));
         im      = 12'($urandom_range(0, 4095));
         v.sub   = 1'b0;
         v.imm   = 12'h000;
         v.delay = $urandom_range(0, 3);
         case (v.kind)
            K_R: begin
               v.sub  = 1'($urandom_range(0, 1));
               v.word = {1'b0, v.sub, 5'b00000, v.rs2, v.rs1, 3'b000, v.rd, 7'b0110011};
            end
            K_I: begin
               v.imm  = im;
               v.word = {im, v.rs1, 3'b000, v.rd, 7'b0010011};
            end
            K_L: begin
               v.imm  = im;
               v.word = {im, v.rs1, 3'b011, v.rd, 7'b0000011};
            end
            K_S: begin
               v.imm  = im;
               v.word = {im[11:5], v.rs2, v.rs1, 3'b011, im[4:0], 7'b0100011};
            end
            default: begin
               v.word = {7'b0000000, v.rs2, v.rs1, 3'($urandom_range(1, 7)), v.rd, 7'b0110011};
            end
         endcase
         run_instr(v, $sformatf("rand%0d", n));
         if (v.kind == K_ILL) begin
            check_halt(3, $sformatf("rand%0d halt", n));
            reset_dut($sformatf("rand%0d reset", n));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IM_ADDR_W, default 32: width of PC and IM_ADDR.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 IM_REQ  output  1  instruction fetch request.
REQ-006 IM_ADDR  output  IM_ADDR_W  fetch address, equals PC.
REQ-007 IM_ACK  input  1  fetch complete; IM_DATA valid in the same cycle.
REQ-008 IM_DATA  input  32  fetched instruction word.
REQ-009 rs1, rs2, rd  output  5 each  register selects to datapath.
REQ-010 immediate  output  12  I/S immediate to datapath.
REQ-011 sub  output  1  ALU subtract select.
REQ-012 WE_RF  output  1  regfile write enable.
REQ-013 WE_MEM  output  1  data memory write enable.
REQ-014 RF_din_sel  output  1  1 = ALU result to regfile, 0 = memory data.
REQ-015 ULA_din2_sel  output  1  1 = immediate to ALU operand 2, 0 = rs2 data.
REQ-016 INSTR_DONE  output  1  one-cycle pulse when an instruction retires.
REQ-017 ILLEGAL  output  1  sticky flag, set on unsupported instruction.

Function
REQ-018 Supported: add/sub (opcode 0110011, funct3 000, funct7 0000000/0100000), addi (0010011, funct3 000), ld (0000011, funct3 011), sd (0100011, funct3 011); every other encoding illegal.
REQ-019 States: FETCH, DECODE, EXEC, MEM, HALT.
REQ-020 FETCH: IM_REQ=1, IM_ADDR=PC held stable until IM_ACK; on IM_ACK latch IM_DATA into IR, go to DECODE.
REQ-021 IM_ACK outside FETCH shall be ignored.
REQ-022 DECODE (1 cycle): legal -> EXEC; illegal -> set ILLEGAL, go to HALT, PC unchanged.
REQ-023 EXEC (1 cycle): add/sub/addi assert WE_RF, RF_din_sel=1, pulse INSTR_DONE, PC+=4, go to FETCH; ld/sd go to MEM.
REQ-024 MEM (1 cycle): ld asserts WE_RF with RF_din_sel=0; sd asserts WE_MEM; both pulse INSTR_DONE, PC+=4, go to FETCH.
REQ-025 rs1/rs2/rd/immediate/sub/ULA_din2_sel decoded from IR, stable from DECODE through the last cycle of the instruction.
REQ-026 immediate: I-type IR[31:20]; S-type {IR[31:25],IR[11:7]}; R-type 0.
REQ-027 sub = IR[30] for R-type only, else 0; ULA_din2_sel=1 for addi/ld/sd, 0 for R-type.
REQ-028 WE_RF shall be suppressed when rd=0; INSTR_DONE still pulses.
REQ-029 WE_RF and WE_MEM shall never both be 1, and each is high for at most one cycle per instruction.
REQ-030 PC increments modulo 2^IM_ADDR_W (wrap from all-ones-minus-3 to 0).
REQ-031 HALT: all enables 0, IM_REQ=0, remain until RST.
REQ-032 Latency: ALU ops retire 2 cycles after IM_ACK cycle; ld/sd 3 cycles.

Reset
REQ-033 RST=1 immediately forces state=FETCH, PC=RESET_PC, IR=0, WE_RF=WE_MEM=INSTR_DONE=ILLEGAL=0, irrespective of CLK.
REQ-034 RST mid-instruction aborts it with no regfile/memory write; IM_REQ asserts first rising edge after RST deasserts.

Structure
REQ-035 Shared package rv_pkg holds opcode, funct3, funct7 constants and the state enumeration.
REQ-036 Combinational sub-module instr_decoder (IR -> fields, immediate, class, legal flag); FSM, PC and IR stay in control_unit.

Verification
REQ-037 IM_DATA=0x002081B3 (add x3,x1,x2), ACK first cycle -> rs1=1, rs2=2, rd=3, sub=0, ULA_din2_sel=0, WE_RF=1 one cycle, IM_ADDR then 0x4.
REQ-038 0x402081B3 then 0xFFF00293 -> sub=1 on first; second immediate=0xFFF, rd=5, ULA_din2_sel=1, WE_RF=1, RF_din_sel=1.
REQ-039 0x0080B303 (ld x6,8(x1)) -> immediate=0x008, WE_RF=1 in MEM with RF_din_sel=0, 3 cycles after ACK; 0x0020B823 (sd) -> immediate=0x010, rs2=2, WE_MEM=1, WE_RF=0.
REQ-040 IM_DATA=0x00000000 -> ILLEGAL=1, HALT, no enables, IM_REQ=0 forever; RST clears, fetch at RESET_PC.
REQ-041 IM_ACK delayed 5 cycles -> IM_ADDR stable; RST pulse during MEM of sd -> WE_MEM stays 0, PC=RESET_PC.
REQ-042 addi x0,x0,1 (0x00100013) -> WE_RF=0, INSTR_DONE=1; PC=0xFFFFFFFC retire -> IM_ADDR=0x0.
